// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit (shift-add multiply, restoring divide).
// Ports: clock/reset/flush; in_valid/in_ready/funct3/src1/src2 request side;
//        out_valid/out_ready/result response side; busy = not idle.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         op_q, op_d;
    logic               neg_q, neg_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   result_q, result_d;

    // Accept-time decode
    logic             accept;
    logic             is_div;
    logic             s1_signed;
    logic             s2_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] mag1;
    logic [WIDTH-1:0] mag2;
    logic             div_zero;
    logic             div_ovf;
    logic             special;
    logic [WIDTH-1:0] special_res;

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;

    assign accept = in_valid & in_ready & ~flush;
    assign is_div = funct3[2];

    // MULH, MULHSU, DIV, REM treat rs1 as signed; MULH, DIV, REM treat rs2 as signed
    assign s1_signed = (funct3 == 3'b001) | (funct3 == 3'b010)
                     | (funct3 == 3'b100) | (funct3 == 3'b110);
    assign s2_signed = (funct3 == 3'b001) | (funct3 == 3'b100)
                     | (funct3 == 3'b110);

    assign a_neg = s1_signed & src1[WIDTH-1];
    assign b_neg = s2_signed & src2[WIDTH-1];
    assign mag1  = a_neg ? -src1 : src1;
    assign mag2  = b_neg ? -src2 : src2;

    assign div_zero = is_div & (src2 == '0);
    assign div_ovf  = is_div & ~funct3[0]
                    & (src1 == MIN_NEG) & (src2 == ALL_ONES);
    assign special  = div_zero | div_ovf;

    always_comb begin
        special_res = '0;
        if (div_zero) begin
            special_res = funct3[1] ? src1 : ALL_ONES;
        end else if (div_ovf) begin
            special_res = funct3[1] ? '0 : src1;
        end
    end

    // Multiply step: acc = {partial high, remaining multiplier bits}
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;

    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                    + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide step: acc = {partial remainder, dividend/quotient}
    logic [WIDTH:0]     rem_sh;
    logic               rem_ge;
    logic [WIDTH-1:0]   rem_sub;
    logic [2*WIDTH-1:0] div_next;

    assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign rem_ge   = (rem_sh >= {1'b0, opnd_q});
    // Difference is below the divisor when taken, so WIDTH bits suffice
    assign rem_sub  = rem_sh[WIDTH-1:0] - opnd_q;
    assign div_next = {rem_ge ? rem_sub : rem_sh[WIDTH-1:0],
                       acc_q[WIDTH-2:0], rem_ge};

    // Sign correction
    logic [2*WIDTH-1:0] mul_fix;
    logic [WIDTH-1:0]   div_sel;
    logic [WIDTH-1:0]   fix_res;

    assign mul_fix = neg_q ? -acc_q : acc_q;
    assign div_sel = op_q[1] ? acc_q[2*WIDTH-1:WIDTH] : acc_q[WIDTH-1:0];

    always_comb begin
        fix_res = '0;
        if (op_q[2]) begin
            fix_res = neg_q ? -div_sel : div_sel;
        end else if (op_q == 3'b000) begin
            fix_res = mul_fix[WIDTH-1:0];
        end else begin
            fix_res = mul_fix[2*WIDTH-1:WIDTH];
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_d    = neg_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        result_d = result_q;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d = funct3;
                    // Remainder follows dividend sign; quotient/product use xor
                    neg_d = (is_div & funct3[1]) ? a_neg : (a_neg ^ b_neg);
                    if (special) begin
                        result_d = special_res;
                        state_d  = S_DONE;
                    end else begin
                        cnt_d   = '0;
                        opnd_d  = is_div ? mag2 : mag1;
                        acc_d   = {{WIDTH{1'b0}}, is_div ? mag1 : mag2};
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                acc_d = op_q[2] ? div_next : mul_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                result_d = fix_res;
                state_d  = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (flush) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit: directed RV32M cases, special cases, back-pressure,
// flush, async reset and a random run against a behavioural reference model.
module tb_muldiv_unit;

    localparam int W = 32;

    logic          clock = 1'b0;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    funct3;
    logic [W-1:0]  src1;
    logic [W-1:0]  src2;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic          busy;

    muldiv_unit #(.WIDTH(W)) dut (
        .clock    (clock),
        .reset    (reset),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .funct3   (funct3),
        .src1     (src1),
        .src2     (src2),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .busy     (busy)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic [W-1:0] exp_q[$];
    int cmp = 0;
    int fails = 0;
    int last_acc = 0;

    function automatic logic [W-1:0] ref_model(input logic [2:0] f,
                                               input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        logic [63:0] p;
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
        case (f)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
            3'd2: begin p = {{32{a[31]}}, a} * {32'b0, b}; return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (ovf) return a;
                return 32'(sa / sb);
            end
            3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                return 32'(sa % sb);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f,
                                      input logic [W-1:0] a,
                                      input logic [W-1:0] b);
        return f[2] && ((b == 0) ||
               (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
    endfunction

    // Drive one op; returns one cycle after the accept edge.
    task automatic issue(input logic [2:0] f, input logic [W-1:0] a,
                         input logic [W-1:0] b, input bit push,
                         input logic [W-1:0] exp);
        int n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clock); #1; n++;
        end
        if (!in_ready) begin
            cmp++; fails++;
            $display("FAIL issue_timeout: in_ready=%b expected 1", in_ready);
        end
        funct3   = f;
        src1     = a;
        src2     = b;
        in_valid = 1'b1;
        if (push) exp_q.push_back(exp);
        @(posedge clock); #1;
        last_acc = cyc;
        in_valid = 1'b0;
        funct3   = 3'($urandom);
        src1     = $urandom;
        src2     = $urandom;
    endtask

    // Count edges after the accept edge until out_valid is seen.
    task automatic wait_out(output int edges, output bit ok);
        edges = 0;
        while (!out_valid && edges < W + 10) begin
            @(posedge clock); #1; edges++;
        end
        ok = out_valid;
    endtask

    task automatic take();
        if (out_valid) begin
            @(posedge clock); #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        funct3 = 3'd0; src1 = '0; src2 = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        cmp++;
        if (in_ready !== 1'b1) begin
            fails++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        cmp++;
        if (out_valid !== 1'b0) begin
            fails++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        cmp++;
        if (busy !== 1'b0) begin
            fails++; $display("FAIL reset_busy: got %b expected 0", busy);
        end
        cmp++;
        if (result !== '0) begin
            fails++; $display("FAIL reset_result: got %h expected 0", result);
        end
    endtask

    task automatic test_mul();
        logic [2:0] fs[4];
        logic [W-1:0] as[4];
        logic [W-1:0] bs[4];
        logic [W-1:0] es[4];
        logic [W-1:0] exp;
        int e;
        bit ok;
        fs = '{3'd0, 3'd1, 3'd3, 3'd2};
        as = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
        bs = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'd2};
        es = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF};
        for (int i = 0; i < 4; i++) begin
            issue(fs[i], as[i], bs[i], 1'b1, es[i]);
            wait_out(e, ok);
            exp = exp_q.pop_front();
            cmp++;
            if (!ok || result !== exp) begin
                fails++;
                $display("FAIL mul[%0d]: got %h valid=%b expected %h", i, result, out_valid, exp);
            end
            cmp++;
            if (e != W + 1) begin
                fails++;
                $display("FAIL mul_latency[%0d]: got %0d edges expected %0d", i, e, W + 1);
            end
            take();
        end
    endtask

    task automatic test_div();
        logic [2:0] fs[5];
        logic [W-1:0] as[5];
        logic [W-1:0] bs[5];
        logic [W-1:0] es[5];
        logic [W-1:0] exp;
        int e;
        bit ok;
        fs = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd4};
        as = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100, 32'd20};
        bs = '{32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFFFFFD};
        es = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2, 32'hFFFFFFFA};
        for (int i = 0; i < 5; i++) begin
            issue(fs[i], as[i], bs[i], 1'b1, es[i]);
            wait_out(e, ok);
            exp = exp_q.pop_front();
            cmp++;
            if (!ok || result !== exp) begin
                fails++;
                $display("FAIL div[%0d]: got %h valid=%b expected %h", i, result, out_valid, exp);
            end
            cmp++;
            if (e != W + 1) begin
                fails++;
                $display("FAIL div_latency[%0d]: got %0d edges expected %0d", i, e, W + 1);
            end
            take();
        end
    endtask

    // Special cases are written on the accept edge itself.
    task automatic test_special();
        logic [2:0] fs[4];
        logic [W-1:0] as[4];
        logic [W-1:0] bs[4];
        logic [W-1:0] es[4];
        logic [W-1:0] exp;
        int e;
        bit ok;
        fs = '{3'd5, 3'd7, 3'd4, 3'd6};
        as = '{32'd5, 32'd5, 32'h80000000, 32'h80000000};
        bs = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        es = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0};
        for (int i = 0; i < 4; i++) begin
            issue(fs[i], as[i], bs[i], 1'b1, es[i]);
            wait_out(e, ok);
            exp = exp_q.pop_front();
            cmp++;
            if (!ok || result !== exp) begin
                fails++;
                $display("FAIL special[%0d]: got %h valid=%b expected %h", i, result, out_valid, exp);
            end
            cmp++;
            if (e != 0) begin
                fails++;
                $display("FAIL special_latency[%0d]: got %0d extra edges expected 0", i, e);
            end
            take();
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] exp;
        logic [W-1:0] r0;
        int e;
        bit ok;
        out_ready = 1'b0;
        issue(3'd5, 32'd100, 32'd7, 1'b1, 32'd14);
        wait_out(e, ok);
        exp = exp_q.pop_front();
        cmp++;
        if (!ok || result !== exp) begin
            fails++;
            $display("FAIL bp_result: got %h valid=%b expected %h", result, out_valid, exp);
        end
        r0 = result;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            cmp++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== r0) begin
                fails++;
                $display("FAIL bp_hold[%0d]: valid=%b ready=%b result=%h expected 1 0 %h",
                         i, out_valid, in_ready, result, r0);
            end
        end
        out_ready = 1'b1;
        @(posedge clock); #1;
        cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL bp_release: ready=%b valid=%b busy=%b expected 1 0 0",
                     in_ready, out_valid, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] exp;
        int a0;
        int e;
        bit ok;
        issue(3'd0, 32'd6, 32'd7, 1'b1, 32'd42);
        a0 = last_acc;
        wait_out(e, ok);
        exp = exp_q.pop_front();
        cmp++;
        if (!ok || result !== exp) begin
            fails++; $display("FAIL b2b_first: got %h expected %h", result, exp);
        end
        take();
        issue(3'd7, 32'd50, 32'd8, 1'b1, 32'd2);
        cmp++;
        if (last_acc - a0 != W + 3) begin
            fails++;
            $display("FAIL b2b_spacing: got %0d cycles expected %0d", last_acc - a0, W + 3);
        end
        wait_out(e, ok);
        exp = exp_q.pop_front();
        cmp++;
        if (!ok || result !== exp) begin
            fails++; $display("FAIL b2b_second: got %h expected %h", result, exp);
        end
        take();
    endtask

    task automatic test_flush();
        logic [W-1:0] prev;
        logic [W-1:0] exp;
        bit saw;
        int e;
        bit ok;
        prev = result;
        issue(3'd3, 32'hDEADBEEF, 32'h12345678, 1'b0, '0);
        repeat (10) begin
            @(posedge clock); #1;
        end
        flush = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0;
        cmp++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL flush_idle: ready=%b busy=%b valid=%b expected 1 0 0",
                     in_ready, busy, out_valid);
        end
        cmp++;
        if (result !== prev) begin
            fails++; $display("FAIL flush_result: got %h expected %h", result, prev);
        end
        saw = 1'b0;
        repeat (W + 5) begin
            @(posedge clock); #1;
            if (out_valid) saw = 1'b1;
        end
        cmp++;
        if (saw) begin
            fails++; $display("FAIL flush_no_valid: out_valid seen 1 expected 0");
        end
        funct3 = 3'd0; src1 = 32'd9; src2 = 32'd9;
        in_valid = 1'b1;
        flush = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        flush = 1'b0;
        cmp++;
        if (busy !== 1'b0) begin
            fails++; $display("FAIL flush_blocks_accept: busy=%b expected 0", busy);
        end
        issue(3'd0, 32'd3, 32'd4, 1'b1, 32'd12);
        wait_out(e, ok);
        exp = exp_q.pop_front();
        cmp++;
        if (!ok || result !== exp) begin
            fails++; $display("FAIL flush_next_mul: got %h expected %h", result, exp);
        end
        take();
    endtask

    task automatic test_async_reset();
        logic [W-1:0] exp;
        int e;
        bit ok;
        issue(3'd4, 32'd1000, 32'd3, 1'b0, '0);
        repeat (5) begin
            @(posedge clock); #1;
        end
        @(negedge clock); #2;
        reset = 1'b1;
        #1;
        cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: ready=%b valid=%b busy=%b expected 1 0 0",
                     in_ready, out_valid, busy);
        end
        cmp++;
        if (result !== '0) begin
            fails++; $display("FAIL async_reset_result: got %h expected 0", result);
        end
        @(negedge clock);
        reset = 1'b0;
        issue(3'd6, 32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFF);
        wait_out(e, ok);
        exp = exp_q.pop_front();
        cmp++;
        if (!ok || result !== exp) begin
            fails++; $display("FAIL post_reset_op: got %h expected %h", result, exp);
        end
        take();
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            4: return 32'h7FFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        logic [2:0] f;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
        int lat;
        int e;
        bit ok;
        for (int i = 0; i < 1000; i++) begin
            f = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            lat = is_special(f, a, b) ? 0 : W + 1;
            issue(f, a, b, 1'b1, ref_model(f, a, b));
            wait_out(e, ok);
            exp = exp_q.pop_front();
            cmp++;
            if (!ok || result !== exp) begin
                fails++;
                $display("FAIL rand[%0d] f=%0d a=%h b=%h: got %h expected %h",
                         i, f, a, b, result, exp);
            end
            cmp++;
            if (e != lat) begin
                fails++;
                $display("FAIL rand_latency[%0d]: got %0d expected %0d", i, e, lat);
            end
            take();
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, fails);
        $finish;
    end

endmodule
